mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped 32-bit timer/compare peripheral on the core's data-memory port, beside `data_ram`. It decodes the same `ce/we/addr/sel/data` bus, owns a 16-byte register window at `BASE_ADDR`, and counts on a (optionally prescaled) tick. On compare match it sets a sticky flag and raises a level interrupt toward the core. The top-level ORs its `data_o` with the RAM's read data; the RAM is gated off this window by the top-level.

## Interface
- `BASE_ADDR`, default 32'h1000_0000: window base; bits [3:0] ignored.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `ce`  in  1: bus access enable.
- `we`  in  1: write strobe, qualified by `ce`.
- `addr`  in  32: byte address.
- `sel`  in  4: byte lane enables; `sel[i]` enables bits [8i+7:8i].
- `data_i`  in  32: write data.
- `data_o`  out  32: read data, combinational.
- `irq_o`  out  1: interrupt, level, registered-state derived.

## Operation
- Hit: `hit = ce & (addr[31:4] == BASE_ADDR[31:4])`. Offset = `addr[3:2]`.
- Write: commits on rising `clk` when `hit & we`. Only lanes with `sel` set change.
- Register map:
  - 0x0 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN, [15:8] PRESCALE. Other bits read 0.
  - 0x4 COUNT: r/w.
  - 0x8 COMPARE: r/w.
  - 0xC STATUS: bit0 MATCH, write-1-to-clear per lane; other bits read 0.
- Read: `data_o` = selected register when `hit & ~we`, else 32'h0. `sel` is ignored on reads.
- Tick: when EN=1, the 8-bit prescale counter `pc` increments each cycle. When `pc == PRESCALE`, `pc` resets to 0 and a tick fires. With PRESCALE=0 a tick fires every cycle. EN=0 holds both `pc` and COUNT.
- On a tick:
  - `nxt = COUNT + 1` (32-bit, wraps 0xFFFF_FFFF → 0).
  - If `nxt == COMPARE`: MATCH ← 1, and COUNT ← 0 if AUTORELOAD=1, else COUNT ← `nxt`.
  - Otherwise COUNT ← `nxt`.
- `irq_o = MATCH & IRQEN`.
- Priorities in one cycle:
  - A bus write to COUNT overrides the tick update; lanes not written take the tick value.
  - MATCH set by a tick beats a W1C clear in the same cycle.
  - Writing CTRL resets `pc` to 0.

## Timing
- Reset (async, `rst`=0): CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, MATCH=0, `pc`=0. Hence `data_o`=0 and `irq_o`=0.
- Write latency: a register written at edge N is readable in cycle N (after the edge).
- Read latency: 0 cycles, combinational from `addr`.
- Match timing:
  - MATCH is visible the cycle after the tick edge that produced `nxt == COMPARE`.
  - `irq_o` asserts in that same cycle if IRQEN=1.
- Matches are detected only on a tick. Writing COUNT equal to COMPARE does not set MATCH.
- COMPARE=0 with AUTORELOAD=1 matches only on wrap, from 0xFFFF_FFFF to 0.
- Reset mid-count clears everything immediately; no pending tick survives.

## Configuration
- `MMIO_TIMER_PRESCALE_EN` defined: prescaler present as described; CTRL[15:8] is r/w.
- Not defined:
  - No `pc` register.
  - A tick fires every cycle while EN=1.
  - CTRL[15:8] is read-only 0; writes to it are ignored.

## Test plan
- Reset: hold `rst`=0, read 0x0/0x4/0x8/0xC → 0, 0, 0xFFFF_FFFF, 0; `irq_o`=0.
- Byte-lane write: COMPARE ← 0xAABBCCDD with `sel`=4'b0010 → reads 0xFFFF_CCFF. Miss address 0x2000_0008 → no change, `data_o`=0.
- Compare/IRQ:
  - Setup: COMPARE=5, CTRL=0x5 (EN, IRQEN), PRESCALE=0.
  - MATCH and `irq_o` rise 5 cycles after the CTRL write.
  - COUNT reads 5, then continues to 6, 7, …
  - W1C to STATUS drops `irq_o` the next cycle.
- Auto-reload with prescale (macro on):
  - Setup: CTRL = EN | AUTORELOAD | PRESCALE=3, COMPARE=2.
  - COUNT follows 0,1,0,1…, changing every 4 cycles.
  - MATCH is set at the first reload.
- Wrap and simultaneous events:
  - Set COUNT=0xFFFF_FFFE, COMPARE=0, AUTORELOAD=0 → COUNT wraps to 0 and MATCH sets.
  - W1C issued on the matching tick cycle → MATCH stays 1.
  - COUNT write on a tick cycle → written value wins.
- Async reset mid-count: assert `rst`=0 between edges while EN=1 → all registers return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer/compare peripheral with sticky match flag and level IRQ.
// Optional prescaler enabled by defining MMIO_TIMER_PRESCALE_EN.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_o
);

  localparam logic [1:0] OFF_CTRL  = 2'd0;
  localparam logic [1:0] OFF_COUNT = 2'd1;
  localparam logic [1:0] OFF_CMP   = 2'd2;
  localparam logic [1:0] OFF_STAT  = 2'd3;

  logic        hit;
  logic        wr;
  logic        rd;
  logic [1:0]  off;
  logic [31:0] wmask;

  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_cmp;
  logic        wr_stat;

  logic        en;
  logic        arl;
  logic        ien;
  logic [7:0]  presc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        match;

  logic        tick;
  logic [31:0] nxt;
  logic        cmp_hit;
  logic [31:0] cnt_tick;

  logic        unused;

  assign hit = ce & (addr[31:4] == BASE_ADDR[31:4]);
  assign off = addr[3:2];
  assign wr  = hit & we;
  assign rd  = hit & ~we;

  assign wmask = {{8{sel[3]}}, {8{sel[2]}},
                  {8{sel[1]}}, {8{sel[0]}}};

  assign wr_ctrl  = wr & (off == OFF_CTRL);
  assign wr_count = wr & (off == OFF_COUNT);
  assign wr_cmp   = wr & (off == OFF_CMP);
  assign wr_stat  = wr & (off == OFF_STAT);

  assign unused = ^addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en  <= 1'b0;
      arl <= 1'b0;
      ien <= 1'b0;
    end else if (wr_ctrl & sel[0]) begin
      en  <= data_i[0];
      arl <= data_i[1];
      ien <= data_i[2];
    end
  end

`ifdef MMIO_TIMER_PRESCALE_EN
  logic [7:0] pc;
  logic       pc_hit;

  assign pc_hit = (pc == presc);
  assign tick   = en & pc_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= 8'h00;
    end else if (wr_ctrl & sel[1]) begin
      presc <= data_i[15:8];
    end
  end

  // Any CTRL write restarts the prescale phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= 8'h00;
    end else if (wr_ctrl) begin
      pc <= 8'h00;
    end else if (en) begin
      pc <= pc_hit ? 8'h00 : pc + 8'h01;
    end
  end
`else
  assign presc = 8'h00;
  assign tick  = en;
`endif

  assign nxt     = count + 32'd1;
  assign cmp_hit = tick & (nxt == compare);

  always_comb begin
    cnt_tick = count;
    if (tick) begin
      cnt_tick = (cmp_hit & arl) ? 32'h0 : nxt;
    end
  end

  // Written lanes beat the tick; other lanes keep the tick result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 32'h0;
    end else if (wr_count) begin
      count <= (data_i & wmask) | (cnt_tick & ~wmask);
    end else begin
      count <= cnt_tick;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      compare <= 32'hFFFF_FFFF;
    end else if (wr_cmp) begin
      compare <= (data_i & wmask) | (compare & ~wmask);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match <= 1'b0;
    end else if (cmp_hit) begin
      match <= 1'b1;
    end else if (wr_stat & sel[0] & data_i[0]) begin
      match <= 1'b0;
    end
  end

  always_comb begin
    data_o = 32'h0;
    if (rd) begin
      unique case (off)
        OFF_CTRL:  data_o = {16'h0, presc, 5'h0, ien, arl, en};
        OFF_COUNT: data_o = count;
        OFF_CMP:   data_o = compare;
        OFF_STAT:  data_o = {31'h0, match};
        default:   data_o = 32'h0;
      endcase
    end
  end

  assign irq_o = match & ien;

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: driver queues expected read data and irq,
// a negedge monitor pops and compares.
module tb_mmio_timer;

`ifdef MMIO_TIMER_PRESCALE_EN
  localparam bit PS = 1'b1;
`else
  localparam bit PS = 1'b0;
`endif

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        irq_o;

  typedef struct {
    string       nm;
    logic [31:0] d;
    logic        q;
  } exp_t;

  exp_t sb[$];
  logic chk;
  int   checks;
  int   errors;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .we(we),
    .addr(addr),
    .sel(sel),
    .data_i(data_i),
    .data_o(data_o),
    .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (chk) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: no expected entry, data_o=%h", data_o);
      end else begin
        e = sb.pop_front();
        checks += 2;
        if (data_o !== e.d) begin
          errors++;
          $display("FAIL %s data: got %h want %h", e.nm, data_o, e.d);
        end
        if (irq_o !== e.q) begin
          errors++;
          $display("FAIL %s irq: got %b want %b", e.nm, irq_o, e.q);
        end
      end
    end
  end

  task automatic idle_bus();
    ce     = 1'b0;
    we     = 1'b0;
    chk    = 1'b0;
    addr   = 32'h0;
    sel    = 4'h0;
    data_i = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    ce     = 1'b1;
    we     = 1'b1;
    addr   = a;
    data_i = d;
    sel    = s;
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d,
                    input logic q, input string nm);
    exp_t e;
    e.nm = nm;
    e.d  = d;
    e.q  = q;
    sb.push_back(e);
    ce   = 1'b1;
    we   = 1'b0;
    addr = a;
    sel  = 4'hF;
    chk  = 1'b1;
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  task automatic rd_rst_mid(input logic [31:0] a, input string nm);
    exp_t e;
    e.nm = nm;
    e.d  = 32'h0;
    e.q  = 1'b0;
    sb.push_back(e);
    ce   = 1'b1;
    we   = 1'b0;
    addr = a;
    sel  = 4'hF;
    chk  = 1'b1;
    #2;
    rst  = 1'b0;
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_bus();
    @(posedge clk);
    #1;

    rd(BASE + 32'h0, 32'h0,         1'b0, "rst_ctrl");
    rd(BASE + 32'h4, 32'h0,         1'b0, "rst_count");
    rd(BASE + 32'h8, 32'hFFFF_FFFF, 1'b0, "rst_cmp");
    rd(BASE + 32'hC, 32'h0,         1'b0, "rst_stat");
    rst = 1'b1;

    wr(BASE + 32'h8, 32'hAABB_CCDD, 4'b0010);
    rd(BASE + 32'h8, 32'hFFFF_CCFF, 1'b0, "lane_cmp");
    wr(32'h2000_0008, 32'h0, 4'hF);
    rd(BASE + 32'h8, 32'hFFFF_CCFF, 1'b0, "miss_nochg");
    rd(32'h2000_0008, 32'h0, 1'b0, "miss_read");

    wr(BASE + 32'h8, 32'd5, 4'hF);
    wr(BASE + 32'h0, 32'h5, 4'hF);
    for (int k = 0; k < 5; k++) begin
      rd(BASE + 32'h4, k, 1'b0, "cnt_pre");
    end
    rd(BASE + 32'h4, 32'd5, 1'b1, "cnt_match");
    rd(BASE + 32'hC, 32'd1, 1'b1, "stat_match");
    rd(BASE + 32'h4, 32'd7, 1'b1, "cnt_post");
    wr(BASE + 32'hC, 32'h1, 4'b0001);
    rd(BASE + 32'hC, 32'd0, 1'b0, "w1c_clear");
    wr(BASE + 32'h0, 32'h0, 4'hF);
    rd(BASE + 32'h4, 32'd11, 1'b0, "cnt_stop");
    rd(BASE + 32'h4, 32'd11, 1'b0, "cnt_hold");

    wr(BASE + 32'h4, 32'h0, 4'hF);
    wr(BASE + 32'h8, 32'd2, 4'hF);
    wr(BASE + 32'hC, 32'h1, 4'hF);
    wr(BASE + 32'h0, 32'h0000_0303, 4'hF);
    for (int k = 0; k < 13; k++) begin
      rd(BASE + 32'h4, PS ? 32'((k / 4) % 2) : 32'(k % 2),
         1'b0, "ar_count");
    end
    rd(BASE + 32'hC, 32'd1, 1'b0, "ar_match");

    wr(BASE + 32'h0, 32'h0, 4'hF);
    wr(BASE + 32'hC, 32'h1, 4'hF);
    wr(BASE + 32'h4, 32'hFFFF_FFFE, 4'hF);
    wr(BASE + 32'h8, 32'h0, 4'hF);
    wr(BASE + 32'h0, 32'h1, 4'hF);
    rd(BASE + 32'h4, 32'hFFFF_FFFE, 1'b0, "wrap_pre");
    wr(BASE + 32'hC, 32'h1, 4'b0001);
    rd(BASE + 32'h4, 32'h0, 1'b0, "wrap_zero");
    rd(BASE + 32'hC, 32'h1, 1'b0, "match_beats_w1c");
    wr(BASE + 32'h4, 32'h1234_5678, 4'hF);
    rd(BASE + 32'h4, 32'h1234_5678, 1'b0, "cnt_wr_wins");
    rd(BASE + 32'h4, 32'h1234_5679, 1'b0, "cnt_after_wr");
    wr(BASE + 32'h4, 32'h0000_00AB, 4'b0001);
    rd(BASE + 32'h4, 32'h1234_56AB, 1'b0, "cnt_lane_merge");

    wr(BASE + 32'h0, 32'hFFFF_FFFE, 4'hF);
    rd(BASE + 32'h0, PS ? 32'h0000_FF06 : 32'h0000_0006,
       1'b1, "ctrl_readback");
    wr(BASE + 32'h0, 32'h5, 4'hF);
    rd(BASE + 32'hC, 32'h1, 1'b1, "pre_reset_irq");

    rd_rst_mid(BASE + 32'h4, "async_rst_count");
    rd(BASE + 32'h0, 32'h0,         1'b0, "async_rst_ctrl");
    rd(BASE + 32'h8, 32'hFFFF_FFFF, 1'b0, "async_rst_cmp");
    rd(BASE + 32'hC, 32'h0,         1'b0, "async_rst_stat");
    rst = 1'b1;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
